// File: rtl/mul_mac_pipe.sv
// mul_mac_pipe: pipelined multiply / multiply-accumulate FU with shift, guarded accumulator and saturating writes
module mul_mac_pipe #(
    parameter int D_WIDTH         = 16,
    parameter int NUM_INPUTS      = 4,
    parameter int NUM_OUTPUTS     = 2,
    parameter int SRC_WIDTH       = 2,
    parameter int DEST_WIDTH      = 1,
    parameter int SHIFT_WIDTH     = 5,
    parameter int ACC_GUARD       = 8,
    parameter int PIPE_STAGES     = 2,
    parameter int I_DECODED_WIDTH = 16
) (
    input  logic                           iClk,
    input  logic                           iReset,
    input  logic                           iStall,
    input  logic [NUM_INPUTS*D_WIDTH-1:0]  iInputs,
    input  logic [I_DECODED_WIDTH-1:0]     iDecodedInstruction,
    output logic [NUM_OUTPUTS*D_WIDTH-1:0] oOutputs,
    output logic                           oOverflow,
    output logic                           oBusy
);
    localparam int AW       = 2*D_WIDTH + ACC_GUARD;
    localparam int NREG     = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam int DEST_LSB = 2*SRC_WIDTH;
    localparam int OP_LSB   = DEST_LSB + DEST_WIDTH;
    localparam int SH_LSB   = OP_LSB + 3;
    localparam int FLAG_LSB = SH_LSB + SHIFT_WIDTH;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MUL   = 3'd1;
    localparam logic [2:0] OP_MULD  = 3'd2;
    localparam logic [2:0] OP_MAC   = 3'd3;
    localparam logic [2:0] OP_MSU   = 3'd4;
    localparam logic [2:0] OP_ACCLD = 3'd5;
    localparam logic [2:0] OP_RDHI  = 3'd6;
    localparam logic [2:0] OP_RDACC = 3'd7;

    typedef struct packed {
        logic                   valid;
        logic [D_WIDTH-1:0]     a;
        logic [D_WIDTH-1:0]     b;
        logic [DEST_WIDTH-1:0]  dest;
        logic [2:0]             op;
        logic [SHIFT_WIDTH-1:0] shift;
        logic                   isSigned;
        logic                   saturate;
        logic                   outputWrite;
    } stageT;

    stageT issue, ret;
    stageT pipe [NREG];
    logic [D_WIDTH-1:0] outReg [NUM_OUTPUTS];
    logic [D_WIDTH-1:0] rHigher, satVal, rawVal, wrVal;
    logic [AW-1:0] acc, accNext, pExt, aAccExt, satIn;
    logic [D_WIDTH:0] aExt, bExt;
    logic [2*D_WIDTH-1:0] prod, pLog, p;
    logic signed [2*D_WIDTH-1:0] pArith;
    logic retEn, clamp, satUse, wrEn, ovfSet;

    always_comb begin
        issue.valid       = iDecodedInstruction[OP_LSB +: 3] != OP_NOP;
        issue.a           = iInputs[int'(iDecodedInstruction[SRC_WIDTH-1:0])*D_WIDTH +: D_WIDTH];
        issue.b           = iInputs[int'(iDecodedInstruction[SRC_WIDTH +: SRC_WIDTH])*D_WIDTH +: D_WIDTH];
        issue.dest        = iDecodedInstruction[DEST_LSB +: DEST_WIDTH];
        issue.op          = iDecodedInstruction[OP_LSB +: 3];
        issue.shift       = iDecodedInstruction[SH_LSB +: SHIFT_WIDTH];
        issue.isSigned    = iDecodedInstruction[FLAG_LSB];
        issue.saturate    = iDecodedInstruction[FLAG_LSB+1];
        issue.outputWrite = iDecodedInstruction[FLAG_LSB+2];
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            for (int k = 0; k < NREG; k++) pipe[k].valid <= 1'b0;
        end else if (!iStall) begin
            pipe[0] <= issue;
            for (int k = 1; k < NREG; k++) pipe[k] <= pipe[k-1];
        end
    end

    // With a single stage the issuing instruction retires at its own edge.
    if (PIPE_STAGES == 1) begin : gSingle
        always_comb ret = issue;
    end else begin : gMulti
        always_comb ret = pipe[PIPE_STAGES-2];
    end

    always_comb begin
        oBusy = 1'b0;
        for (int k = 0; k < PIPE_STAGES - 1; k++) oBusy = oBusy | pipe[k].valid;
    end

    always_comb begin
        retEn   = ret.valid && !iStall;
        aExt    = {ret.isSigned & ret.a[D_WIDTH-1], ret.a};
        bExt    = {ret.isSigned & ret.b[D_WIDTH-1], ret.b};
        prod    = (2*D_WIDTH)'($signed(aExt) * $signed(bExt));
        pArith  = $signed(prod) >>> ret.shift;
        pLog    = prod >> ret.shift;
        p       = ret.isSigned ? pArith : pLog;
        pExt    = {{ACC_GUARD{ret.isSigned & p[2*D_WIDTH-1]}}, p};
        aAccExt = {{(AW-D_WIDTH){ret.isSigned & ret.a[D_WIDTH-1]}}, ret.a};
        accNext = ret.op == OP_MAC   ? acc + pExt :
                  ret.op == OP_MSU   ? acc - pExt :
                  ret.op == OP_ACCLD ? aAccExt : acc;
        satIn   = ret.op == OP_MUL   ? pExt :
                  ret.op == OP_RDACC ? acc : accNext;
        // Signed values fit when every bit from the D-1 sign position upward agrees.
        clamp   = ret.isSigned ? !((&satIn[AW-1:D_WIDTH-1]) || !(|satIn[AW-1:D_WIDTH-1]))
                               : |satIn[AW-1:D_WIDTH];
        satVal  = !clamp        ? satIn[D_WIDTH-1:0] :
                  !ret.isSigned ? {D_WIDTH{1'b1}} :
                  satIn[AW-1]   ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
        rawVal  = ret.op == OP_RDHI ? rHigher :
                  ret.op == OP_MULD ? p[D_WIDTH-1:0] : satIn[D_WIDTH-1:0];
        satUse  = ret.saturate && (ret.op == OP_MUL || ret.op == OP_MAC ||
                                   ret.op == OP_MSU || ret.op == OP_RDACC);
        wrVal   = satUse ? satVal : rawVal;
        wrEn    = retEn && ret.outputWrite && ret.op != OP_NOP && ret.op != OP_ACCLD;
        ovfSet  = wrEn && satUse && clamp;
    end

    always_ff @(posedge iClk) begin
        if (!iReset) begin
            acc       <= '0;
            rHigher   <= '0;
            oOverflow <= 1'b0;
            for (int k = 0; k < NUM_OUTPUTS; k++) outReg[k] <= '0;
        end else if (retEn) begin
            acc <= accNext;
            if (ret.op == OP_MUL) rHigher <= p[2*D_WIDTH-1:D_WIDTH];
            if (ovfSet) oOverflow <= 1'b1;
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (wrEn && k == int'(ret.dest)) outReg[k] <= wrVal;
                if (wrEn && ret.op == OP_MULD && k == (int'(ret.dest) + 1) % NUM_OUTPUTS)
                    outReg[k] <= p[2*D_WIDTH-1:D_WIDTH];
            end
        end
    end

    always_comb begin
        oOutputs = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) oOutputs[k*D_WIDTH +: D_WIDTH] = outReg[k];
    end
endmodule

// File: tb/tb_mul_mac_pipe.sv
// tb_mul_mac_pipe: directed vector table, hand sequences and randomized run against a queue-based reference model
module tb_mul_mac_pipe;
    localparam int PS = 2;
    localparam longint AMASK = (longint'(1) << 40) - 1;

    logic        iClk = 1'b0;
    logic        iReset, iStall;
    logic [63:0] iInputs;
    logic [15:0] iDecodedInstruction;
    logic [31:0] oOutputs;
    logic        oOverflow, oBusy;

    mul_mac_pipe #(.PIPE_STAGES(PS)) dut (
        .iClk(iClk), .iReset(iReset), .iStall(iStall), .iInputs(iInputs),
        .iDecodedInstruction(iDecodedInstruction), .oOutputs(oOutputs),
        .oOverflow(oOverflow), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          dest;
        int          op;
        int          sh;
        bit          sg;
        bit          sat;
        bit          ow;
    } mopT;

    typedef struct {
        bit          rstn;
        bit          stall;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] instr;
        logic [15:0] e0;
        logic [15:0] e1;
        bit          eo;
        bit          eb;
        string       name;
    } vecT;

    mopT         q[$];
    longint      mAcc;
    logic [15:0] mHi;
    logic [15:0] mOut [2];
    bit          mOvf;
    int          nTests = 0;
    int          nFail = 0;
    vecT         tbl[$];

    function automatic logic [15:0] mk(int op, int dest, int sh, bit sg, bit sat, bit ow);
        return {ow, sat, sg, 5'(sh), 3'(op), 1'(dest), 2'd1, 2'd0};
    endfunction

    function automatic mopT decode(logic [63:0] ins, logic [15:0] instr);
        mopT o;
        o.a    = ins[int'(instr[1:0])*16 +: 16];
        o.b    = ins[int'(instr[3:2])*16 +: 16];
        o.dest = int'(instr[4]);
        o.op   = int'(instr[7:5]);
        o.sh   = int'(instr[12:8]);
        o.sg   = instr[13];
        o.sat  = instr[14];
        o.ow   = instr[15];
        return o;
    endfunction

    function automatic longint accVal(bit sg);
        return (sg && mAcc[39]) ? mAcc - (longint'(1) << 40) : mAcc;
    endfunction

    // Destination write with optional clamp of the full-precision value v.
    function automatic void wr(mopT o, longint v, logic [15:0] raw);
        longint lo, hi;
        if (!o.ow) return;
        lo = o.sg ? -32768 : 0;
        hi = o.sg ? 32767 : 65535;
        if (o.sat && v > hi) begin mOut[o.dest] = 16'(hi); mOvf = 1; end
        else if (o.sat && v < lo) begin mOut[o.dest] = 16'(lo); mOvf = 1; end
        else mOut[o.dest] = raw;
    endfunction

    function automatic void exec(mopT o);
        longint av, bv, p;
        logic [63:0] pb;
        av = o.sg ? longint'($signed(o.a)) : longint'(o.a);
        bv = o.sg ? longint'($signed(o.b)) : longint'(o.b);
        p  = (av * bv) >>> o.sh;
        pb = p;
        case (o.op)
            1: begin wr(o, p, pb[15:0]); mHi = pb[31:16]; end
            2: if (o.ow) begin mOut[o.dest] = pb[15:0]; mOut[(o.dest + 1) % 2] = pb[31:16]; end
            3: begin mAcc = (mAcc + p) & AMASK; wr(o, accVal(o.sg), mAcc[15:0]); end
            4: begin mAcc = (mAcc - p) & AMASK; wr(o, accVal(o.sg), mAcc[15:0]); end
            5: mAcc = av & AMASK;
            6: if (o.ow) mOut[o.dest] = mHi;
            7: wr(o, accVal(o.sg), mAcc[15:0]);
            default: ;
        endcase
    endfunction

    function automatic void modelStep(bit rstn, bit stall, mopT o);
        if (!rstn) begin
            q.delete();
            mAcc = 0; mHi = 0; mOut[0] = 0; mOut[1] = 0; mOvf = 0;
        end else if (!stall) begin
            q.push_back(o);
            if (q.size() > PS - 1) exec(q.pop_front());
        end
    endfunction

    function automatic bit modelBusy();
        foreach (q[i]) if (q[i].op != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(bit rstn, bit stall, logic [63:0] ins, logic [15:0] instr);
        iReset = rstn; iStall = stall; iInputs = ins; iDecodedInstruction = instr;
        @(posedge iClk);
        #1;
        modelStep(rstn, stall, decode(ins, instr));
    endtask

    task automatic add(bit rstn, logic [15:0] a, logic [15:0] b, logic [15:0] instr,
                       logic [15:0] e0, logic [15:0] e1, bit eo, bit eb, string name);
        vecT v;
        v.rstn = rstn; v.stall = 0; v.a = a; v.b = b; v.instr = instr;
        v.e0 = e0; v.e1 = e1; v.eo = eo; v.eb = eb; v.name = name;
        tbl.push_back(v);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'($urandom % 16);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        iReset = 0; iStall = 0; iInputs = '0; iDecodedInstruction = '0;
        add(0, 0, 0, 0,                          16'h0000, 16'h0000, 0, 0, "reset");
        add(1, 16'h0100, 16'h0200, mk(1,0,8,1,0,1), 16'h0000, 16'h0000, 0, 1, "mul_issue");
        add(1, 0, 0, 0,                          16'h0200, 16'h0000, 0, 0, "mul_retire");
        add(1, 0, 0, mk(6,0,0,0,0,1),            16'h0200, 16'h0000, 0, 1, "rdhi_issue");
        add(1, 16'hFFFF, 16'hFFFF, mk(2,1,0,0,0,1), 16'h0000, 16'h0000, 0, 1, "rdhi_retire");
        add(1, 0, 0, 0,                          16'hFFFE, 16'h0001, 0, 0, "muld_wrap");
        add(1, 5, 0, mk(5,0,0,0,0,1),            16'hFFFE, 16'h0001, 0, 1, "accld_issue");
        add(1, 3, 4, mk(3,0,0,0,0,1),            16'hFFFE, 16'h0001, 0, 1, "accld_nowrite");
        add(1, 3, 4, mk(3,0,0,0,0,1),            16'h0011, 16'h0001, 0, 1, "mac1");
        add(1, 3, 4, mk(3,0,0,0,0,1),            16'h001D, 16'h0001, 0, 1, "mac2");
        add(1, 0, 0, mk(7,1,0,0,0,1),            16'h0029, 16'h0001, 0, 1, "mac3");
        add(1, 0, 0, 0,                          16'h0029, 16'h0029, 0, 0, "rdacc");
        add(1, 16'h7FF0, 0, mk(5,0,0,1,0,0),     16'h0029, 16'h0029, 0, 1, "accld_s");
        add(1, 16'h0020, 1, mk(3,0,0,1,1,1),     16'h0029, 16'h0029, 0, 1, "mac_sat_issue");
        add(1, 0, 0, 0,                          16'h7FFF, 16'h0029, 1, 0, "mac_sat");
        add(1, 16'h7FF0, 0, mk(5,0,0,1,0,0),     16'h7FFF, 16'h0029, 1, 1, "ovf_sticky");
        add(1, 16'h0020, 1, mk(3,0,0,1,0,1),     16'h7FFF, 16'h0029, 1, 1, "mac_nosat_issue");
        add(1, 0, 0, 0,                          16'h8010, 16'h0029, 1, 0, "mac_nosat");
        foreach (tbl[i]) begin
            step(tbl[i].rstn, tbl[i].stall, {32'h0, tbl[i].b, tbl[i].a}, tbl[i].instr);
            chk({tbl[i].name, "_out"}, oOutputs, {tbl[i].e1, tbl[i].e0});
            chk({tbl[i].name, "_flags"}, {30'h0, oOverflow, oBusy}, {30'h0, tbl[i].eo, tbl[i].eb});
        end

        // Stall mid-pipeline: operands and instructions seen during the stall are ignored.
        step(0, 0, '0, '0);
        step(1, 0, {32'h0, 16'd6, 16'd7}, mk(1,0,0,0,0,1));
        chk("stall_issue", {15'h0, oBusy, oOutputs[15:0]}, {15'h0, 1'b1, 16'h0000});
        for (int i = 0; i < 3; i++) begin
            step(1, 1, {32'h0, 16'h5678, 16'h1234}, mk(1,0,0,0,0,1));
            chk("stall_hold", {15'h0, oBusy, oOutputs[15:0]}, {15'h0, 1'b1, 16'h0000});
        end
        step(1, 0, '0, '0);
        chk("stall_release", {15'h0, oBusy, oOutputs[15:0]}, {15'h0, 1'b0, 16'd42});
        step(1, 0, '0, '0);
        chk("stall_no_dup", {15'h0, oBusy, oOutputs[15:0]}, {15'h0, 1'b0, 16'd42});

        // Reset with work in flight and another op presented at the reset edge.
        step(1, 0, {32'h0, 16'd6, 16'd7}, mk(1,1,0,0,0,1));
        chk("rst_pre_busy", {31'h0, oBusy}, 32'h1);
        step(0, 0, {32'h0, 16'd6, 16'd7}, mk(1,1,0,0,0,1));
        chk("rst_out", oOutputs, 32'h0);
        chk("rst_flags", {30'h0, oOverflow, oBusy}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, '0, '0);
            chk("rst_no_retire", {15'h0, oBusy, oOutputs[15:0]}, 32'h0);
            chk("rst_no_retire_hi", {16'h0, oOutputs[31:16]}, 32'h0);
        end

        step(0, 0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] instr;
            bit rstn, stall;
            instr = 16'($urandom);
            rstn  = ($urandom % 60) != 0;
            stall = ($urandom % 7) == 0;
            step(rstn, stall, {pick(), pick(), pick(), pick()}, instr);
            chk("rand_out", oOutputs, {mOut[1], mOut[0]});
            chk("rand_ovf", {31'h0, oOverflow}, {31'h0, mOvf});
            chk("rand_busy", {31'h0, oBusy}, {31'h0, modelBusy()});
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
